// File: rtl/issue_queue_dual_if.sv
// Bundle of every non-clock/reset signal between the decode stage,
// the dual-entry issue queue and the dual-issue launch stage.
interface issue_queue_dual_if #(
  parameter int DECODE_WIDTH = 64,
  parameter int DEPTH        = 8
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                    flush;

  logic                    in_valid1;
  logic [31:0]             in_pc1;
  logic [31:0]             in_npc1;
  logic [31:0]             in_inst1;
  logic [DECODE_WIDTH-1:0] in_decode1;

  logic                    in_valid2;
  logic [31:0]             in_pc2;
  logic [31:0]             in_npc2;
  logic [31:0]             in_inst2;
  logic [DECODE_WIDTH-1:0] in_decode2;

  logic                    in_ready;

  logic [31:0]             out_pc1;
  logic [31:0]             out_npc1;
  logic [31:0]             out_inst1;
  logic [DECODE_WIDTH-1:0] out_decode1;
  logic                    receive_flag1;

  logic [31:0]             out_pc2;
  logic [31:0]             out_npc2;
  logic [31:0]             out_inst2;
  logic [DECODE_WIDTH-1:0] out_decode2;
  logic                    receive_flag2;

  logic [3:0]              launch_flag;
  logic [CNT_W-1:0]        count;

  // Producer / launch-stage side
  modport master (
    output flush,
    output in_valid1, in_pc1, in_npc1, in_inst1, in_decode1,
    output in_valid2, in_pc2, in_npc2, in_inst2, in_decode2,
    output launch_flag,
    input  in_ready,
    input  out_pc1, out_npc1, out_inst1, out_decode1, receive_flag1,
    input  out_pc2, out_npc2, out_inst2, out_decode2, receive_flag2,
    input  count
  );

  // Queue side
  modport slave (
    input  flush,
    input  in_valid1, in_pc1, in_npc1, in_inst1, in_decode1,
    input  in_valid2, in_pc2, in_npc2, in_inst2, in_decode2,
    input  launch_flag,
    output in_ready,
    output out_pc1, out_npc1, out_inst1, out_decode1, receive_flag1,
    output out_pc2, out_npc2, out_inst2, out_decode2, receive_flag2,
    output count
  );
endinterface

// File: rtl/issue_queue_dual.sv
// In-order dual-push / dual-pop instruction queue feeding the dual-issue
// launch stage. Circular buffer with head/tail pointers and an occupancy
// counter; the two oldest entries are presented combinationally.
module issue_queue_dual #(
  parameter int DECODE_WIDTH = 64,
  parameter int DEPTH        = 8
) (
  input  logic               clk,
  input  logic               rst,
  issue_queue_dual_if.slave  q
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [31:0]             pc;
    logic [31:0]             npc;
    logic [31:0]             inst;
    logic [DECODE_WIDTH-1:0] decode;
  } entry_t;

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             inReady;
  logic             pushEn;
  logic             launch1, launch2;
  logic [CNT_W-1:0] pushN, popReq, popN;
  logic [PTR_W-1:0] tailPlus1, wrAddr2, headPlus1;
  entry_t           slot1, slot2, head0, head1;

  // Push/pop accounting and next pointer/occupancy values; flush clears all
  always_comb begin
    inReady   = (count_q <= CNT_W'(DEPTH - 2));
    pushEn    = inReady && !q.flush;

    pushN     = '0;
    if (pushEn) pushN = CNT_W'(q.in_valid1) + CNT_W'(q.in_valid2);

    launch1   = q.launch_flag[3] | q.launch_flag[2];
    launch2   = q.launch_flag[1] | q.launch_flag[0];
    popReq    = '0;
    if (launch1) popReq = launch2 ? CNT_W'(2) : CNT_W'(1);
    popN      = (popReq > count_q) ? count_q : popReq;

    tailPlus1 = tail_q + PTR_W'(1);
    wrAddr2   = q.in_valid1 ? tailPlus1 : tail_q;

    head_d    = head_q + popN[PTR_W-1:0];
    tail_d    = tail_q + pushN[PTR_W-1:0];
    count_d   = count_q + pushN - popN;
    if (q.flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Incoming slots packed into storage entries
  always_comb begin
    slot1 = '{pc: q.in_pc1, npc: q.in_npc1, inst: q.in_inst1, decode: q.in_decode1};
    slot2 = '{pc: q.in_pc2, npc: q.in_npc2, inst: q.in_inst2, decode: q.in_decode2};
  end

  // Compacted write of valid slots at tail / tail+1; storage is never cleared
  always_ff @(posedge clk) begin
    if (!rst && pushEn) begin
      if (q.in_valid1) mem_q[tail_q]  <= slot1;
      if (q.in_valid2) mem_q[wrAddr2] <= slot2;
    end
  end

  // Head and head+1 reads, zeroed when the slot holds no valid entry
  always_comb begin
    headPlus1 = head_q + PTR_W'(1);
    head0     = (count_q >= CNT_W'(1)) ? mem_q[head_q]    : '0;
    head1     = (count_q >= CNT_W'(2)) ? mem_q[headPlus1] : '0;
  end

  assign q.in_ready      = inReady;
  assign q.count         = count_q;
  assign q.receive_flag1 = (count_q >= CNT_W'(1));
  assign q.receive_flag2 = (count_q >= CNT_W'(2));
  assign q.out_pc1       = head0.pc;
  assign q.out_npc1      = head0.npc;
  assign q.out_inst1     = head0.inst;
  assign q.out_decode1   = head0.decode;
  assign q.out_pc2       = head1.pc;
  assign q.out_npc2      = head1.npc;
  assign q.out_inst2     = head1.inst;
  assign q.out_decode2   = head1.decode;
endmodule

// File: tb/tb_issue_queue_dual.sv
// Self-checking bench for issue_queue_dual: directed scenarios followed by
// random traffic, all compared against a queue-based reference model.
module tb_issue_queue_dual;
  localparam int DW    = 64;
  localparam int DEPTH = 8;

  typedef struct {
    logic [31:0]   pc;
    logic [31:0]   npc;
    logic [31:0]   inst;
    logic [DW-1:0] decode;
  } ent_t;

  logic clk;
  logic rst;
  int   nChecks = 0;
  int   nFails  = 0;
  ent_t model[$];

  issue_queue_dual_if #(.DECODE_WIDTH(DW), .DEPTH(DEPTH)) bus ();

  issue_queue_dual #(.DECODE_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .q   (bus.slave)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts and reports a mismatch
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Compare every output against the reference queue contents
  task automatic checkAll();
    ent_t e0, e1;
    int   n;
    n  = model.size();
    e0 = '{pc: 0, npc: 0, inst: 0, decode: 0};
    e1 = e0;
    if (n >= 1) e0 = model[0];
    if (n >= 2) e1 = model[1];
    checkOutput("count",    64'(bus.count),         64'(n));
    checkOutput("in_ready", 64'(bus.in_ready),      64'(n <= DEPTH - 2));
    checkOutput("rflag1",   64'(bus.receive_flag1), 64'(n >= 1));
    checkOutput("rflag2",   64'(bus.receive_flag2), 64'(n >= 2));
    checkOutput("pc1",      64'(bus.out_pc1),       64'(e0.pc));
    checkOutput("npc1",     64'(bus.out_npc1),      64'(e0.npc));
    checkOutput("inst1",    64'(bus.out_inst1),     64'(e0.inst));
    checkOutput("dec1",     bus.out_decode1,        e0.decode);
    checkOutput("pc2",      64'(bus.out_pc2),       64'(e1.pc));
    checkOutput("npc2",     64'(bus.out_npc2),      64'(e1.npc));
    checkOutput("inst2",    64'(bus.out_inst2),     64'(e1.inst));
    checkOutput("dec2",     bus.out_decode2,        e1.decode);
  endtask

  // Drive one cycle of inputs, check outputs, advance model and clock
  task automatic applyStimulus(input logic v1, input logic [31:0] pc1,
                               input logic v2, input logic [31:0] pc2,
                               input logic [3:0] lf, input logic fl, input logic r);
    ent_t e1, e2;
    int   popN;
    bit   ready;
    e1 = '{pc: pc1, npc: pc1 + 32'd4, inst: $urandom, decode: {$urandom, $urandom}};
    e2 = '{pc: pc2, npc: pc2 + 32'd4, inst: $urandom, decode: {$urandom, $urandom}};
    rst                = r;
    bus.flush          = fl;
    bus.launch_flag    = lf;
    bus.in_valid1      = v1;
    bus.in_pc1         = e1.pc;
    bus.in_npc1        = e1.npc;
    bus.in_inst1       = e1.inst;
    bus.in_decode1     = e1.decode;
    bus.in_valid2      = v2;
    bus.in_pc2         = e2.pc;
    bus.in_npc2        = e2.npc;
    bus.in_inst2       = e2.inst;
    bus.in_decode2     = e2.decode;
    #1;
    checkAll();
    if (r || fl) begin
      model.delete();
    end else begin
      ready = (model.size() <= DEPTH - 2);
      popN  = 0;
      if (lf[3] || lf[2]) popN = (lf[1] || lf[0]) ? 2 : 1;
      if (popN > model.size()) popN = model.size();
      repeat (popN) void'(model.pop_front());
      if (ready) begin
        if (v1) model.push_back(e1);
        if (v2) model.push_back(e2);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 4'b0000, 1'b0, 1'b0);
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 4'b0000, 1'b0, 1'b1);
  endtask

  task automatic pushPair(input logic [31:0] pc, input logic [3:0] lf);
    applyStimulus(1'b1, pc, 1'b1, pc + 32'd4, lf, 1'b0, 1'b0);
  endtask

  // Test sequence
  initial begin
    logic [31:0] pcRun;
    rst = 1'b1;
    bus.flush = 1'b0; bus.launch_flag = 4'b0;
    bus.in_valid1 = 1'b0; bus.in_pc1 = '0; bus.in_npc1 = '0; bus.in_inst1 = '0; bus.in_decode1 = '0;
    bus.in_valid2 = 1'b0; bus.in_pc2 = '0; bus.in_npc2 = '0; bus.in_inst2 = '0; bus.in_decode2 = '0;
    repeat (2) @(posedge clk);
    #1;
    model.delete();

    // Reset state, then a two-entry push
    pushPair(32'h8000_0000, 4'b0000);
    checkOutput("tp1_count", 64'(bus.count), 64'd2);
    checkOutput("tp1_pc1", 64'(bus.out_pc1), 64'h8000_0000);
    checkOutput("tp1_pc2", 64'(bus.out_pc2), 64'h8000_0004);

    // Single pop, then illegal l2-only launch
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 4'b1000, 1'b0, 1'b0);
    checkOutput("tp2_count", 64'(bus.count), 64'd1);
    checkOutput("tp2_pc1", 64'(bus.out_pc1), 64'h8000_0004);
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 4'b0001, 1'b0, 1'b0);
    checkOutput("tp2_hold", 64'(bus.count), 64'd1);

    // Fill to full, dropped push, drain in order
    doReset();
    pcRun = 32'h1000;
    for (int i = 0; i < 4; i++) begin
      pushPair(pcRun, 4'b0000);
      pcRun += 32'd8;
    end
    checkOutput("tp3_full", 64'(bus.count), 64'd8);
    checkOutput("tp3_ready", 64'(bus.in_ready), 64'd0);
    pushPair(32'hDEAD_0000, 4'b0000);
    checkOutput("tp3_drop", 64'(bus.count), 64'd8);
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 4'b1001, 1'b0, 1'b0);
    checkOutput("tp3_empty", 64'(bus.count), 64'd0);

    // Steady state with wrap-around
    doReset();
    pcRun = 32'h2000;
    for (int i = 0; i < 3; i++) begin
      pushPair(pcRun, 4'b0000);
      pcRun += 32'd8;
    end
    for (int i = 0; i < 4; i++) begin
      pushPair(pcRun, 4'b1001);
      pcRun += 32'd8;
      checkOutput("tp4_count", 64'(bus.count), 64'd6);
    end
    checkOutput("tp4_pc1", 64'(bus.out_pc1), 64'h2020);
    idle();

    // Slot-2-only push into an empty queue
    doReset();
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h100, 4'b0000, 1'b0, 1'b0);
    checkOutput("tp5_pc1", 64'(bus.out_pc1), 64'h100);
    checkOutput("tp5_rf2", 64'(bus.receive_flag2), 64'd0);
    checkOutput("tp5_pc2", 64'(bus.out_pc2), 64'd0);
    idle();

    // Flush with concurrent push and pop
    doReset();
    pushPair(32'h3000, 4'b0000);
    pushPair(32'h3008, 4'b0000);
    applyStimulus(1'b1, 32'h3010, 1'b0, 32'h0, 4'b0000, 1'b0, 1'b0);
    checkOutput("tp6_five", 64'(bus.count), 64'd5);
    applyStimulus(1'b1, 32'h3014, 1'b1, 32'h3018, 4'b1010, 1'b1, 1'b0);
    checkOutput("tp6_count", 64'(bus.count), 64'd0);
    checkOutput("tp6_ready", 64'(bus.in_ready), 64'd1);
    idle();

    // Reset mid-fill with a push
    pushPair(32'h4000, 4'b0000);
    applyStimulus(1'b1, 32'h4008, 1'b0, 32'h0, 4'b0000, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h400C, 1'b1, 32'h4010, 4'b1010, 1'b0, 1'b1);
    checkOutput("tp6_rst_count", 64'(bus.count), 64'd0);
    checkOutput("tp6_rst_pc1", 64'(bus.out_pc1), 64'd0);
    idle();

    // Random traffic
    pcRun = 32'h9000_0000;
    for (int i = 0; i < 500; i++) begin
      logic       v1, v2, fl, r;
      logic [3:0] lf;
      v1 = 1'($urandom);
      v2 = 1'($urandom);
      lf = ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom);
      fl = ($urandom_range(0, 20) == 0);
      r  = ($urandom_range(0, 60) == 0);
      applyStimulus(v1, pcRun, v2, pcRun + 32'd4, lf, fl, r);
      pcRun += 32'd8;
    end
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule
